// File: rtl/adder_seq_32b_ctrl.sv
// Two-pass 32-bit add controller sequencing one external 16-bit adder (low half, then high half).
// Optional subtract mode is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_32b_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [31:0] req_in0,
    input  logic [31:0] req_in1,
    input  logic        req_cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic        req_sub,
`endif
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_sum,
    output logic        resp_cout,
    output logic [15:0] add_in0,
    output logic [15:0] add_in1,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        carry_q, carry_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic [31:0] b_cap_s;
    logic        cin_cap_s;

    // Operand conditioning at capture: subtract is A + ~B + 1.
    always_comb begin
        b_cap_s   = req_in1;
        cin_cap_s = req_cin;
`ifdef ADDER_SEQ_SUB_EN
        if (req_sub) begin
            b_cap_s   = ~req_in1;
            cin_cap_s = 1'b1;
        end else begin
            b_cap_s   = req_in1;
            cin_cap_s = req_cin;
        end
`endif
    end

    // Next-state, datapath register updates and adder/handshake outputs.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        add_in0  = 16'd0;
        add_in1  = 16'd0;
        add_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    a_d     = req_in0;
                    b_d     = b_cap_s;
                    cin_d   = cin_cap_s;
                    state_d = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                add_in0      = a_q[15:0];
                add_in1      = b_q[15:0];
                add_cin      = cin_q;
                sum_d[15:0]  = add_sum;
                carry_d      = add_cout;
                state_d      = HI;
            end
            HI: begin
                add_in0      = a_q[31:16];
                add_in1      = b_q[31:16];
                add_cin      = carry_q;
                sum_d[31:16] = add_sum;
                cout_d       = add_cout;
                state_d      = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= 32'd0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign resp_sum  = sum_q;
    assign resp_cout = cout_q;

endmodule

// File: tb/tb_adder_seq_32b_ctrl.sv
// Directed self-checking bench for adder_seq_32b_ctrl with a behavioural 16-bit shared adder.
module tb_adder_seq_32b_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_in0;
    logic [31:0] req_in1;
    logic        req_cin;
    logic        req_sub;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_sum;
    logic        resp_cout;
    logic [15:0] add_in0;
    logic [15:0] add_in1;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // Shared adder: combinational 16-bit sum with carry.
    assign {add_cout, add_sum} = {1'b0, add_in0} + {1'b0, add_in1} + {16'd0, add_cin};

    adder_seq_32b_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_cin   (req_cin),
`ifdef ADDER_SEQ_SUB_EN
        .req_sub   (req_sub),
`endif
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_sum  (resp_sum),
        .resp_cout (resp_cout),
        .add_in0   (add_in0),
        .add_in1   (add_in1),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Complete one transaction from IDLE and return its result (bounded wait).
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, output logic [31:0] sum, output logic cout);
        int k;
        req_val = 1'b1; req_in0 = a; req_in1 = b; req_cin = cin; req_sub = sub;
        resp_rdy = 1'b1;
        step();
        req_val = 1'b0;
        k = 0;
        while (!resp_val && k < 10) begin
            step();
            k++;
        end
        chk("txn_timeout", {31'd0, resp_val}, 32'd1);
        sum  = resp_sum;
        cout = resp_cout;
        step();
        resp_rdy = 1'b0;
    endtask

    logic [31:0] rsum [2];
    logic        rcout[2];
    logic [31:0] tsum;
    logic        tcout;
    int nres, acc0, acc1, nhigh;
    bit got1;

    initial begin
        rst_n = 1'b0; req_val = 1'b0; req_in0 = 32'd0; req_in1 = 32'd0;
        req_cin = 1'b0; req_sub = 1'b0; resp_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_rdy",   {31'd0, req_rdy},   32'd1);
        chk("rst_resp_val",  {31'd0, resp_val},  32'd0);
        chk("rst_resp_sum",  resp_sum,           32'd0);
        chk("rst_resp_cout", {31'd0, resp_cout}, 32'd0);
        chk("rst_add_in0",   {16'd0, add_in0},   32'd0);
        chk("rst_add_in1",   {16'd0, add_in1},   32'd0);
        chk("rst_add_cin",   {31'd0, add_cin},   32'd0);
        rst_n = 1'b1;

        // Carry chaining across halves; operands scrambled after accept.
        req_val = 1'b1; req_in0 = 32'h0000FFFF; req_in1 = 32'h00000001; req_cin = 1'b0;
        step();
        req_val = 1'b0; req_in0 = 32'hDEADBEEF; req_in1 = 32'hDEADBEEF; req_cin = 1'b1;
        chk("lo_req_rdy",  {31'd0, req_rdy},  32'd0);
        chk("lo_resp_val", {31'd0, resp_val}, 32'd0);
        chk("lo_add_in0",  {16'd0, add_in0},  32'h0000FFFF);
        chk("lo_add_in1",  {16'd0, add_in1},  32'h00000001);
        chk("lo_add_cin",  {31'd0, add_cin},  32'd0);
        step();
        chk("hi_resp_val", {31'd0, resp_val}, 32'd0);
        chk("hi_add_in0",  {16'd0, add_in0},  32'd0);
        chk("hi_add_in1",  {16'd0, add_in1},  32'd0);
        chk("hi_add_cin",  {31'd0, add_cin},  32'd1);
        step();
        chk("c1_resp_val",  {31'd0, resp_val},  32'd1);
        chk("c1_resp_sum",  resp_sum,           32'h00010000);
        chk("c1_resp_cout", {31'd0, resp_cout}, 32'd0);
        chk("c1_req_rdy",   {31'd0, req_rdy},   32'd0);
        chk("done_add_in0", {16'd0, add_in0},   32'd0);
        chk("done_add_cin", {31'd0, add_cin},   32'd0);
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
        chk("c1_idle_rdy",  {31'd0, req_rdy},  32'd1);
        chk("c1_idle_val",  {31'd0, resp_val}, 32'd0);
        chk("c1_sum_hold",  resp_sum,          32'h00010000);

        // Full carry with backpressure.
        req_val = 1'b1; req_in0 = 32'hFFFFFFFF; req_in1 = 32'h00000000; req_cin = 1'b1;
        step();
        req_val = 1'b0;
        chk("c2_lo_add_in0", {16'd0, add_in0}, 32'h0000FFFF);
        chk("c2_lo_add_cin", {31'd0, add_cin}, 32'd1);
        step();
        chk("c2_hi_add_in0", {16'd0, add_in0}, 32'h0000FFFF);
        chk("c2_hi_add_cin", {31'd0, add_cin}, 32'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            req_val = (i == 2) ? 1'b1 : 1'b0;
            req_in0 = 32'h00000005; req_in1 = 32'h00000006; req_cin = 1'b0;
            chk("bp_resp_val",  {31'd0, resp_val},  32'd1);
            chk("bp_resp_sum",  resp_sum,           32'h00000000);
            chk("bp_resp_cout", {31'd0, resp_cout}, 32'd1);
            chk("bp_req_rdy",   {31'd0, req_rdy},   32'd0);
            step();
        end
        req_val = 1'b0;
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
        chk("bp_release_rdy", {31'd0, req_rdy}, 32'd1);
        step();
        chk("bp_no_capture", {31'd0, req_rdy}, 32'd1);

        // Reset while in HI: request dropped, never answered.
        req_val = 1'b1; req_in0 = 32'h12345678; req_in1 = 32'h11111111; req_cin = 1'b0;
        step();
        req_val = 1'b0;
        step();
        chk("rm_in_hi", {16'd0, add_in0}, 32'h00001234);
        rst_n = 1'b0;
        #1;
        chk("rm_req_rdy",  {31'd0, req_rdy},  32'd1);
        chk("rm_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rm_add_in0",  {16'd0, add_in0},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_rdy = 1'b1;
        nhigh = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_val) nhigh++;
        end
        chk("rm_no_resp", nhigh, 32'd0);
        chk("rm_idle",    {31'd0, req_rdy}, 32'd1);

        // Back-to-back with req_val and resp_rdy held high.
        req_val = 1'b1; resp_rdy = 1'b1; req_cin = 1'b0;
        req_in0 = 32'h00000001; req_in1 = 32'h00000002;
        acc0 = cyc; nres = 0; got1 = 1'b0; acc1 = 0;
        step();
        req_in0 = 32'h80000000; req_in1 = 32'h80000000;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_val && nres < 2) begin
                rsum[nres]  = resp_sum;
                rcout[nres] = resp_cout;
                nres++;
            end
            if (req_rdy && !got1) begin
                acc1 = cyc;
                got1 = 1'b1;
            end
        end
        req_val = 1'b0;
        chk("b2b_nres",  nres, 32'd2);
        chk("b2b_gap",   acc1 - acc0, 32'd4);
        chk("b2b_sum0",  rsum[0], 32'd3);
        chk("b2b_cout0", {31'd0, rcout[0]}, 32'd0);
        chk("b2b_sum1",  rsum[1], 32'd0);
        chk("b2b_cout1", {31'd0, rcout[1]}, 32'd1);
        resp_rdy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        resp_rdy = 1'b0;

        // Mixed-carry vector through the generic transaction task.
        do_txn(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, tsum, tcout);
        chk("mix_sum",  tsum, 32'h00000000);
        chk("mix_cout", {31'd0, tcout}, 32'd1);
        do_txn(32'h00008000, 32'h00008000, 1'b0, 1'b0, tsum, tcout);
        chk("half_sum",  tsum, 32'h00010000);
        chk("half_cout", {31'd0, tcout}, 32'd0);

`ifdef ADDER_SEQ_SUB_EN
        do_txn(32'd5, 32'd7, 1'b0, 1'b1, tsum, tcout);
        chk("sub_5m7_sum",  tsum, 32'hFFFFFFFE);
        chk("sub_5m7_cout", {31'd0, tcout}, 32'd0);
        do_txn(32'd7, 32'd5, 1'b0, 1'b1, tsum, tcout);
        chk("sub_7m5_sum",  tsum, 32'h00000002);
        chk("sub_7m5_cout", {31'd0, tcout}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
